// File: rtl/cs_sequencer.sv
// cs_sequencer: microcode control-store address sequencer (RUN/HOLD/FAULT).
// Optional 4-entry return stack with Call_In/Return_In when CS_RETURN_STACK_EN is defined.
module cs_sequencer #(
    parameter int DATAWIDTH_BUS = 32,
    parameter int CSADDR_WIDTH  = 11
) (
    input  logic                     CLK,
    input  logic                     RESET_InLow,
    input  logic [1:0]               Control_Branch_In,
    input  logic [CSADDR_WIDTH-1:0]  JumpAddr_In,
    input  logic [DATAWIDTH_BUS-1:0] IR_In,
    input  logic                     Stall_In,
`ifdef CS_RETURN_STACK_EN
    input  logic                     Call_In,
    input  logic                     Return_In,
`endif
    output logic [CSADDR_WIDTH-1:0]  CSAddress_Out,
    output logic                     Fault_Out,
    output logic [1:0]               State_Out
);
    localparam int AW = CSADDR_WIDTH;

    typedef enum logic [1:0] {RUN = 2'b00, HOLD = 2'b01, FAULT = 2'b10} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] csar, csar_nxt, sel_addr, target, csar_inc;
    logic          fault, fault_nxt, illegal, advance;
    logic [10:0]   decode_addr;

    assign csar_inc    = csar + AW'(1);
    assign decode_addr = {1'b1, IR_In[31:30], IR_In[24:19], 2'b00};
    assign sel_addr    = (Control_Branch_In == 2'b01) ? JumpAddr_In :
                         (Control_Branch_In == 2'b10) ? AW'(decode_addr) : csar_inc;

`ifdef CS_RETURN_STACK_EN
    logic [AW-1:0] stack [4];
    logic [2:0]    depth;
    logic          push, pop;

    assign push    = Call_In && !Return_In && Control_Branch_In == 2'b01;
    assign pop     = Return_In && !Call_In;
    // Return overrides the branch select, including an otherwise illegal one
    assign illegal = (Call_In && Return_In) || (push && depth == 3'd4) ||
                     (pop && depth == 3'd0) || (!pop && Control_Branch_In == 2'b11);
    assign target  = pop ? stack[depth[1:0] - 2'd1] : sel_addr;

    always_ff @(posedge CLK or negedge RESET_InLow) begin
        if (!RESET_InLow)
            depth <= 3'd0;
        else if (advance && push)
            depth <= depth + 3'd1;
        else if (advance && pop)
            depth <= depth - 3'd1;
    end

    always_ff @(posedge CLK) begin
        if (advance && push)
            stack[depth[1:0]] <= csar_inc;
    end
`else
    assign illegal = Control_Branch_In == 2'b11;
    assign target  = sel_addr;
`endif

    assign advance = state != FAULT && !Stall_In && !illegal;

    always_ff @(posedge CLK or negedge RESET_InLow) begin
        if (!RESET_InLow) begin
            state <= RUN;
            csar  <= '0;
            fault <= 1'b0;
        end else begin
            state <= state_nxt;
            csar  <= csar_nxt;
            fault <= fault_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        csar_nxt  = csar;
        fault_nxt = fault;
        if (state != FAULT) begin
            if (Stall_In) begin
                state_nxt = HOLD;
            end else if (illegal) begin
                state_nxt = FAULT;
                fault_nxt = 1'b1;
            end else begin
                state_nxt = RUN;
                csar_nxt  = target;
            end
        end
    end

    always_comb begin
        CSAddress_Out = csar;
        Fault_Out     = fault;
        State_Out     = state;
    end
endmodule

// File: tb/tb_cs_sequencer.sv
// tb_cs_sequencer: table-driven check of cs_sequencer plus reset and return-stack sequences.
// Stack sequences run only when CS_RETURN_STACK_EN is defined.
module tb_cs_sequencer;
    logic        CLK = 1'b0;
    logic        RESET_InLow;
    logic [1:0]  sel;
    logic [10:0] jump;
    logic [31:0] ir;
    logic        stall;
    logic        call_in, ret_in;
    logic [10:0] addr;
    logic        fault;
    logic [1:0]  st;
    int          checks = 0;
    int          errors = 0;

    cs_sequencer dut (
        .CLK(CLK),
        .RESET_InLow(RESET_InLow),
        .Control_Branch_In(sel),
        .JumpAddr_In(jump),
        .IR_In(ir),
        .Stall_In(stall),
`ifdef CS_RETURN_STACK_EN
        .Call_In(call_in),
        .Return_In(ret_in),
`endif
        .CSAddress_Out(addr),
        .Fault_Out(fault),
        .State_Out(st)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  sel;
        logic [10:0] jump;
        logic [31:0] ir;
        logic        stall;
        logic [10:0] addr;
        logic        fault;
        logic [1:0]  st;
    } vec_t;

    vec_t vt[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [10:0] a, input logic f, input logic [1:0] s);
        chk({nm, ".addr"}, 32'(addr), 32'(a));
        chk({nm, ".fault"}, 32'(fault), 32'(f));
        chk({nm, ".state"}, 32'(st), 32'(s));
    endtask

    task automatic step(input logic [1:0] s, input logic [10:0] j, input logic stl, input logic c, input logic r);
        sel = s; jump = j; stall = stl; call_in = c; ret_in = r;
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        #3 RESET_InLow = 1'b0;
        #1;
        chk_all("async_reset", 11'h000, 1'b0, 2'b00);
        @(negedge CLK);
        RESET_InLow = 1'b1;
    endtask

    initial begin
        vt[0]  = '{2'b00, 11'h000, 32'h0,         1'b0, 11'h001, 1'b0, 2'b00};
        vt[1]  = '{2'b00, 11'h000, 32'h0,         1'b0, 11'h002, 1'b0, 2'b00};
        vt[2]  = '{2'b00, 11'h000, 32'h0,         1'b0, 11'h003, 1'b0, 2'b00};
        vt[3]  = '{2'b01, 11'h7FF, 32'h0,         1'b0, 11'h7FF, 1'b0, 2'b00};
        vt[4]  = '{2'b00, 11'h000, 32'h0,         1'b0, 11'h000, 1'b0, 2'b00};
        vt[5]  = '{2'b01, 11'h155, 32'h0,         1'b0, 11'h155, 1'b0, 2'b00};
        vt[6]  = '{2'b10, 11'h000, 32'h8200_0000, 1'b0, 11'h600, 1'b0, 2'b00};
        vt[7]  = '{2'b10, 11'h000, 32'hFFFF_FFFF, 1'b0, 11'h7FC, 1'b0, 2'b00};
        vt[8]  = '{2'b10, 11'h000, 32'h40F8_0000, 1'b0, 11'h57C, 1'b0, 2'b00};
        vt[9]  = '{2'b01, 11'h010, 32'h0,         1'b0, 11'h010, 1'b0, 2'b00};
        vt[10] = '{2'b00, 11'h000, 32'h0,         1'b1, 11'h010, 1'b0, 2'b01};
        vt[11] = '{2'b00, 11'h000, 32'h0,         1'b0, 11'h011, 1'b0, 2'b00};
        vt[12] = '{2'b11, 11'h000, 32'h0,         1'b1, 11'h011, 1'b0, 2'b01};
        vt[13] = '{2'b11, 11'h000, 32'h0,         1'b1, 11'h011, 1'b0, 2'b01};
        vt[14] = '{2'b11, 11'h000, 32'h0,         1'b0, 11'h011, 1'b1, 2'b10};
        vt[15] = '{2'b00, 11'h000, 32'h0,         1'b0, 11'h011, 1'b1, 2'b10};
        vt[16] = '{2'b01, 11'h123, 32'h0,         1'b0, 11'h011, 1'b1, 2'b10};
        vt[17] = '{2'b00, 11'h000, 32'h0,         1'b1, 11'h011, 1'b1, 2'b10};

        RESET_InLow = 1'b0; sel = 2'b00; jump = '0; ir = '0; stall = 1'b0;
        call_in = 1'b0; ret_in = 1'b0;
        repeat (2) @(posedge CLK);
        #1 chk_all("reset", 11'h000, 1'b0, 2'b00);
        @(negedge CLK);
        RESET_InLow = 1'b1;

        for (int i = 0; i < 18; i++) begin
            sel = vt[i].sel; jump = vt[i].jump; ir = vt[i].ir; stall = vt[i].stall;
            @(posedge CLK);
            #1 chk_all($sformatf("vec%0d", i), vt[i].addr, vt[i].fault, vt[i].st);
        end

        // reset out of FAULT mid-cycle, then first edge after release advances
        pulse_reset();
        step(2'b00, 11'h000, 1'b0, 1'b0, 1'b0);
        chk_all("post_reset", 11'h001, 1'b0, 2'b00);

        // reset out of HOLD
        step(2'b00, 11'h000, 1'b1, 1'b0, 1'b0);
        chk_all("hold", 11'h001, 1'b0, 2'b01);
        pulse_reset();
        step(2'b01, 11'h0AA, 1'b0, 1'b0, 1'b0);
        chk_all("hold_reset_jump", 11'h0AA, 1'b0, 2'b00);

`ifdef CS_RETURN_STACK_EN
        pulse_reset();
        step(2'b00, 11'h000, 1'b0, 1'b0, 1'b1);
        chk_all("pop_empty", 11'h000, 1'b1, 2'b10);

        pulse_reset();
        step(2'b01, 11'h010, 1'b0, 1'b0, 1'b0);
        step(2'b01, 11'h100, 1'b0, 1'b1, 1'b0);
        chk_all("call", 11'h100, 1'b0, 2'b00);
        step(2'b00, 11'h000, 1'b0, 1'b0, 1'b0);
        step(2'b01, 11'h3FF, 1'b1, 1'b0, 1'b1);
        chk_all("stall_blocks_pop", 11'h101, 1'b0, 2'b01);
        step(2'b11, 11'h000, 1'b0, 1'b0, 1'b1);
        chk_all("return", 11'h011, 1'b0, 2'b00);

        for (int i = 1; i <= 4; i++) begin
            step(2'b01, 11'(i * 256), 1'b0, 1'b1, 1'b0);
            chk_all($sformatf("nest%0d", i), 11'(i * 256), 1'b0, 2'b00);
        end
        step(2'b01, 11'h600, 1'b0, 1'b1, 1'b0);
        chk_all("nest5_overflow", 11'h400, 1'b1, 2'b10);

        pulse_reset();
        step(2'b01, 11'h050, 1'b0, 1'b1, 1'b1);
        chk_all("call_and_return", 11'h000, 1'b1, 2'b10);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
